memory_arbiter: RTL and testbench

- Parametrised single-port synchronous RAM shared by the instruction-fetch port and the data port of the CPU.
- Successor to the fixed 512x16 memory. Adds width/depth parameters, split read/write data buses (no internal tristate), req/ready handshakes, a selectable arbitration policy with starvation protection, and per-port read-valid strobes.
- Sits between the fetch unit and the load/store unit.

---
 rtl/memory_arbiter.sv | 156 +++++++++++++++
 tb/tb_memory_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// memory_arbiter: single-port synchronous RAM shared by the instruction-fetch
// port (i_*) and the load/store data port (d_*). One RAM access per cycle,
// req/ready handshakes, fixed-priority (with starvation guard) or round-robin
// arbitration, 1-cycle read latency, read-before-write on data writes.
// Optional feature: define MEM_ADDR_FAULT_EN to add sticky out-of-range
// fault flags d_fault / i_fault.
module memory_arbiter #(
  parameter int DW       = 16,
  parameter int AW       = 16,
  parameter int DEPTH    = 512,
  parameter int POLICY   = 0,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ready,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ready,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata
`ifdef MEM_ADDR_FAULT_EN
  ,
  output logic          d_fault,
  output logic          i_fault
`endif
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;

  grant_e        last_grant_q, last_grant_d;
  logic [7:0]    wait_cnt_q, wait_cnt_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] ram_q;
  logic          d_rvalid_q, i_rvalid_q;
  logic          resp_oor_q;
  logic [DW-1:0] d_hold_q, i_hold_q;

  logic          acc_en, acc_we, acc_in_range;
  logic [AW-1:0] acc_addr;
  logic [IW-1:0] acc_idx;
  logic [DW-1:0] resp_data;

  // Arbitration: decide which port (if any) owns the RAM this cycle.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/else tree can leave it unassigned and infer a latch.
    d_ready = 1'b0;
    i_ready = 1'b0;
    if (!rst) begin
      if (d_req && i_req) begin
        if (POLICY == 1) begin
          if (last_grant_q == GRANT_I) d_ready = 1'b1;
          else                         i_ready = 1'b1;
        end else if (wait_cnt_q == 8'(MAX_WAIT)) begin
          i_ready = 1'b1;
        end else begin
          d_ready = 1'b1;
        end
      end else begin
        d_ready = d_req;
        i_ready = i_req;
      end
    end
  end

  // Shared access port: address mux and range decode for the granted request.
  always_comb begin
    acc_en       = d_ready | i_ready;
    acc_we       = d_ready & d_we;
    acc_addr     = d_ready ? d_addr : i_addr;
    acc_in_range = ({1'b0, acc_addr} < (AW + 1)'(DEPTH));
    acc_idx      = acc_addr[IW-1:0];
  end

  // Next-state for the starvation counter and round-robin pointer.
  always_comb begin
    wait_cnt_d   = wait_cnt_q;
    last_grant_d = last_grant_q;
    if (i_ready) begin
      wait_cnt_d = '0;
    end else if (i_req && (wait_cnt_q < 8'(MAX_WAIT))) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
    if (d_ready)      last_grant_d = GRANT_D;
    else if (i_ready) last_grant_d = GRANT_I;
  end

  // RAM array: write-enable plus registered read on a single address.
  // NOTE: the array has no reset; clearing it would need one write per word
  // and would stop it mapping onto block RAM. Contents survive rst.
  always_ff @(posedge clk) begin
    if (acc_en && acc_we && acc_in_range) mem_q[acc_idx] <= d_wdata;
    if (acc_en)                           ram_q          <= mem_q[acc_idx];
  end

  // Response data: out-of-range reads return zero; otherwise the RAM word.
  always_comb begin
    resp_data = resp_oor_q ? '0 : ram_q;
    d_rdata   = d_rvalid_q ? resp_data : d_hold_q;
    i_rdata   = i_rvalid_q ? resp_data : i_hold_q;
    d_rvalid  = d_rvalid_q;
    i_rvalid  = i_rvalid_q;
  end

  // Control state, response strobes and per-port read-data hold registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q   <= '0;
      last_grant_q <= GRANT_I;
      d_rvalid_q   <= 1'b0;
      i_rvalid_q   <= 1'b0;
      resp_oor_q   <= 1'b0;
      d_hold_q     <= '0;
      i_hold_q     <= '0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      last_grant_q <= last_grant_d;
      d_rvalid_q   <= d_ready;
      i_rvalid_q   <= i_ready;
      resp_oor_q   <= ~acc_in_range;
      if (d_rvalid_q) d_hold_q <= d_rdata;
      if (i_rvalid_q) i_hold_q <= i_rdata;
    end
  end

`ifdef MEM_ADDR_FAULT_EN
  logic d_fault_q, i_fault_q;

  // Sticky fault flags: set after a granted out-of-range access, cleared by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_fault_q <= 1'b0;
      i_fault_q <= 1'b0;
    end else begin
      d_fault_q <= d_fault_q | (d_ready & ~acc_in_range);
      i_fault_q <= i_fault_q | (i_ready & ~acc_in_range);
    end
  end

  assign d_fault = d_fault_q;
  assign i_fault = i_fault_q;
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: randomized and directed bench for memory_arbiter.
// dut0 uses the fixed-priority policy, dut1 the round-robin policy; both see
// the same stimulus. A memory-image reference model predicts grants and
// responses. dut1 is checked only while the stimulus keeps both memories equal.
module tb_memory_arbiter;

  localparam int DW       = 16;
  localparam int AW       = 16;
  localparam int DEPTH    = 512;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, d_req, d_we, i_req;
  logic [AW-1:0] d_addr, i_addr;
  logic [DW-1:0] d_wdata;

  logic          d_ready0, d_rvalid0, i_ready0, i_rvalid0;
  logic [DW-1:0] d_rdata0, i_rdata0;
  logic          d_ready1, d_rvalid1, i_ready1, i_rvalid1;
  logic [DW-1:0] d_rdata1, i_rdata1;
`ifdef MEM_ADDR_FAULT_EN
  logic d_fault0, i_fault0, d_fault1, i_fault1;
`endif

  memory_arbiter #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .POLICY(0), .MAX_WAIT(MAX_WAIT)) dut0 (
    .clk(clk), .rst(rst),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready0), .d_rvalid(d_rvalid0), .d_rdata(d_rdata0),
    .i_req(i_req), .i_addr(i_addr),
    .i_ready(i_ready0), .i_rvalid(i_rvalid0), .i_rdata(i_rdata0)
`ifdef MEM_ADDR_FAULT_EN
    , .d_fault(d_fault0), .i_fault(i_fault0)
`endif
  );

  memory_arbiter #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .POLICY(1), .MAX_WAIT(MAX_WAIT)) dut1 (
    .clk(clk), .rst(rst),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
    .i_req(i_req), .i_addr(i_addr),
    .i_ready(i_ready1), .i_rvalid(i_rvalid1), .i_rdata(i_rdata1)
`ifdef MEM_ADDR_FAULT_EN
    , .d_fault(d_fault1), .i_fault(i_fault1)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, act, exp, $time);
    end
  endtask

  // Reference model state.
  logic [DW-1:0] mem_m   [DEPTH];
  bit            known_m [DEPTH];
  int            denials;      // consecutive cycles the fetch port was refused
  bit            rr_last_d;    // round-robin: data port was granted last
  bit            p1_on;        // dut1 checks active

  bit            e_dv, e_iv, e_dk, e_ik;  // dut0 expectations
  logic [DW-1:0] e_dd, e_id;
  bit            f_dv, f_iv, f_dk, f_ik;  // dut1 expectations
  logic [DW-1:0] f_dd, f_id;
  bit            e_dfault, e_ifault;

  bit gd, gi;                              // model grants of the last cycle
  bit obs_d0, obs_i0, obs_d1, obs_i1;      // observed readies of the last cycle

  function automatic void model_read(input logic [AW-1:0] a, output logic [DW-1:0] v, output bit k);
    if (int'(a) < DEPTH) begin
      v = mem_m[a];
      k = known_m[a];
    end else begin
      v = '0;
      k = 1'b1;
    end
  endfunction

  // One clock cycle: inputs are already applied just after a falling edge.
  task automatic cycle();
    bit            g1d, g1i;
    logic [DW-1:0] dv, iv;
    bit            dk, ik;
    #1;
    gd = 1'b0; gi = 1'b0; g1d = 1'b0; g1i = 1'b0;
    if (!rst) begin
      if (d_req && i_req) begin
        gi  = (denials >= MAX_WAIT);
        gd  = !gi;
        g1d = !rr_last_d;
        g1i = rr_last_d;
      end else begin
        gd = d_req;  gi = i_req;
        g1d = d_req; g1i = i_req;
      end
    end
    obs_d0 = d_ready0; obs_i0 = i_ready0;
    obs_d1 = d_ready1; obs_i1 = i_ready1;
    check("d_ready", d_ready0, gd);
    check("i_ready", i_ready0, gi);
    if (p1_on) begin
      check("rr_d_ready", d_ready1, g1d);
      check("rr_i_ready", i_ready1, g1i);
    end
    model_read(d_addr, dv, dk);
    model_read(i_addr, iv, ik);
    @(posedge clk);
    if (rst) begin
      e_dv = 0; e_iv = 0; e_dd = '0; e_id = '0; e_dk = 1; e_ik = 1;
      f_dv = 0; f_iv = 0; f_dd = '0; f_id = '0; f_dk = 1; f_ik = 1;
      denials = 0; rr_last_d = 0; e_dfault = 0; e_ifault = 0;
    end else begin
      e_dv = gd;  e_iv = gi;
      if (gd)  begin e_dd = dv; e_dk = dk; end
      if (gi)  begin e_id = iv; e_ik = ik; end
      f_dv = g1d; f_iv = g1i;
      if (g1d) begin f_dd = dv; f_dk = dk; end
      if (g1i) begin f_id = iv; f_ik = ik; end
      if (gd && d_we && int'(d_addr) < DEPTH) begin
        mem_m[d_addr]   = d_wdata;
        known_m[d_addr] = 1'b1;
      end
      if (gi)                             denials = 0;
      else if (i_req && denials < MAX_WAIT) denials++;
      if (g1d)      rr_last_d = 1'b1;
      else if (g1i) rr_last_d = 1'b0;
      if (gd && int'(d_addr) >= DEPTH) e_dfault = 1'b1;
      if (gi && int'(i_addr) >= DEPTH) e_ifault = 1'b1;
    end
    @(negedge clk);
    check("d_rvalid", d_rvalid0, e_dv);
    check("i_rvalid", i_rvalid0, e_iv);
    if (e_dk) check("d_rdata", d_rdata0, e_dd);
    if (e_ik) check("i_rdata", i_rdata0, e_id);
    if (p1_on) begin
      check("rr_d_rvalid", d_rvalid1, f_dv);
      check("rr_i_rvalid", i_rvalid1, f_iv);
      if (f_dk) check("rr_d_rdata", d_rdata1, f_dd);
      if (f_ik) check("rr_i_rdata", i_rdata1, f_id);
    end
`ifdef MEM_ADDR_FAULT_EN
    check("d_fault", d_fault0, e_dfault);
    check("i_fault", i_fault0, e_ifault);
`endif
  endtask

  // Data-port access held until granted, with a bounded wait.
  task automatic d_op(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    int tries = 0;
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    cycle();
    while (!gd && tries < 50) begin
      cycle();
      tries++;
    end
    if (!gd) check("d_grant_timeout", 32'd0, 32'd1);
    d_req = 1'b0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'(DEPTH - 2 + int'($urandom_range(0, 4)));
    return AW'($urandom_range(0, 15));
  endfunction

  logic [DW-1:0] fetch_words [4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    i_req = 0; i_addr = '0;
    p1_on = 1'b1; denials = 0; rr_last_d = 0;
    e_dk = 0; e_ik = 0; f_dk = 0; f_ik = 0;
    for (int a = 0; a < DEPTH; a++) known_m[a] = 1'b0;
    fetch_words[0] = 16'hA5A0; fetch_words[1] = 16'h5A51;
    fetch_words[2] = 16'h1234; fetch_words[3] = 16'hFEDC;

    // Reset: both readies low, strobes and read data cleared.
    @(negedge clk);
    cycle();
    cycle();
    rst = 1'b0;

    // Bring the whole image to a known zero state through the data port.
    for (int a = 0; a < DEPTH; a++) d_op(1'b1, AW'(a), '0);

    // Write then read: write response returns old word, read returns new.
    d_op(1'b1, 16'h0010, 16'hBF01);
    check("wr_old_word", d_rdata0, 16'h0000);
    d_op(1'b0, 16'h0010, '0);
    check("rd_new_word", d_rdata0, 16'hBF01);
    check("rd_new_valid", d_rvalid0, 1'b1);

    // Out-of-range write discarded, read returns zero with a valid strobe.
    d_op(1'b1, 16'h0200, 16'hFFFF);
`ifdef MEM_ADDR_FAULT_EN
    check("oor_d_fault", d_fault0, 1'b1);
    check("oor_i_fault", i_fault0, 1'b0);
`endif
    d_op(1'b0, 16'h0200, '0);
    check("oor_rd_zero", d_rdata0, 16'h0000);
    check("oor_rd_valid", d_rvalid0, 1'b1);
    d_op(1'b0, 16'h0000, '0);
    check("oor_mem0", d_rdata0, 16'h0000);

    // Fixed-priority contention: four data grants, then the fetch port wins.
    d_req = 1; d_we = 0; d_addr = 16'h0010; i_req = 1; i_addr = 16'h0011;
    for (int k = 0; k < 10; k++) begin
      cycle();
      check("p0_i_grant", obs_i0, (k % 5) == 4);
    end
    d_req = 0; i_req = 0;

    // Round-robin contention after reset: d first, then alternating.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    d_req = 1; d_we = 0; d_addr = 16'h0010; i_req = 1; i_addr = 16'h0011;
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("p1_d_grant", obs_d1, (k % 2) == 0);
      check("p1_i_rvalid", i_rvalid1, (k % 2) == 1);
    end
    d_req = 0; i_req = 0;

    // Fetch stream: four consecutive reads, one word per cycle.
    for (int k = 0; k < 4; k++) d_op(1'b1, AW'(16'h0010 + k), fetch_words[k]);
    i_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_addr = AW'(16'h0010 + k);
      cycle();
      check("fetch_valid", i_rvalid0, 1'b1);
      check("fetch_word", i_rdata0, fetch_words[k]);
    end

    // Reset in the cycle of a fetch: no grant, no strobe, memory kept.
    i_addr = 16'h0012;
    rst = 1'b1;
    cycle();
    check("rst_i_ready", obs_i0, 1'b0);
    check("rst_d_ready", obs_d0, 1'b0);
    check("rst_i_rvalid", i_rvalid0, 1'b0);
    rst = 1'b0;
    cycle();
    check("rst_mem_kept", i_rdata0, fetch_words[2]);
    i_req = 1'b0;

    // Randomized traffic with contention, out-of-range and occasional reset.
    p1_on = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (!d_req || gd) begin
        if ($urandom_range(0, 3) != 0) begin
          d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
          d_addr = rand_addr(); d_wdata = DW'($urandom);
        end else begin
          d_req = 1'b0;
        end
      end
      if (!i_req || gi) begin
        if ($urandom_range(0, 2) != 0) begin
          i_req = 1'b1; i_addr = rand_addr();
        end else begin
          i_req = 1'b0;
        end
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
